// File: rtl/grid_sweeper.sv
// Cell-by-cell sweep controller for the environment grid: one READ (cache lookup)
// and one COMMIT (write strobe) cycle per cell, with pause, abort and overrun tracking.
module grid_sweeper #(
  parameter int X_bits = 8,
  parameter int Y_bits = 7,
  parameter int X_num  = 160,
  parameter int Y_num  = 120
) (
  input  logic              Clk,
  input  logic              RESET_SIM_N,
  input  logic              game_clk,
  input  logic              RUN,
  input  logic              KEY_PAUSE,
  output logic [X_bits-1:0] writeLoc_x,
  output logic [Y_bits-1:0] writeLoc_y,
  output logic              write_flag,
  output logic              hold_locs,
  output logic              busy,
  output logic              sweep_done,
  output logic [7:0]        overrun_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_COMMIT, S_PAUSED, S_DONE} state_t;

  localparam logic [X_bits-1:0] X_LAST = X_bits'(X_num - 1);
  localparam logic [Y_bits-1:0] Y_LAST = Y_bits'(Y_num - 1);

  state_t r_state;
  logic   r_kp_s1, r_kp_s2, r_kp_d;
  logic   r_paused;
  logic   r_gclk_d;

  logic   w_pause_tgl, w_tick;

  // Pushbutton is active-low: each press (falling edge) flips the pause state.
  assign w_pause_tgl = r_kp_d & ~r_kp_s2;
  assign w_tick      = game_clk & ~r_gclk_d;

  always_ff @(posedge Clk) begin
    if (!RESET_SIM_N) begin
      r_kp_s1  <= 1'b1;
      r_kp_s2  <= 1'b1;
      r_kp_d   <= 1'b1;
      r_paused <= 1'b0;
      r_gclk_d <= 1'b0;
    end else begin
      r_kp_s1  <= KEY_PAUSE;
      r_kp_s2  <= r_kp_s1;
      r_kp_d   <= r_kp_s2;
      r_paused <= r_paused ^ w_pause_tgl;
      r_gclk_d <= game_clk;
    end
  end

  // Any tick outside IDLE (including the DONE cycle) is an overrun.
  always_ff @(posedge Clk) begin
    if (!RESET_SIM_N)
      overrun_cnt <= 8'd0;
    else if (w_tick && r_state != S_IDLE && overrun_cnt != 8'hFF)
      overrun_cnt <= overrun_cnt + 8'd1;
  end

  always_ff @(posedge Clk) begin
    if (!RESET_SIM_N) begin
      r_state    <= S_IDLE;
      writeLoc_x <= '0;
      writeLoc_y <= '0;
      write_flag <= 1'b0;
      hold_locs  <= 1'b1;
      busy       <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      write_flag <= 1'b0;
      sweep_done <= 1'b0;
      if (busy && !RUN) begin
        r_state    <= S_IDLE;
        writeLoc_x <= '0;
        writeLoc_y <= '0;
        hold_locs  <= 1'b1;
        busy       <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_tick && RUN && !r_paused) begin
              r_state    <= S_READ;
              writeLoc_x <= '0;
              writeLoc_y <= '0;
              hold_locs  <= 1'b0;
              busy       <= 1'b1;
            end
          end
          S_READ: begin
            r_state    <= S_COMMIT;
            write_flag <= 1'b1;
          end
          S_COMMIT: begin
            if (writeLoc_x == X_LAST && writeLoc_y == Y_LAST) begin
              r_state    <= S_DONE;
              writeLoc_x <= '0;
              writeLoc_y <= '0;
              hold_locs  <= 1'b1;
              busy       <= 1'b0;
              sweep_done <= 1'b1;
            end else begin
              if (writeLoc_x == X_LAST) begin
                writeLoc_x <= '0;
                writeLoc_y <= writeLoc_y + Y_bits'(1);
              end else begin
                writeLoc_x <= writeLoc_x + X_bits'(1);
              end
              // A pause requested mid-cell lands here, after the commit.
              if (r_paused) begin
                r_state   <= S_PAUSED;
                hold_locs <= 1'b1;
              end else begin
                r_state   <= S_READ;
              end
            end
          end
          S_PAUSED: begin
            if (!r_paused) begin
              r_state   <= S_READ;
              hold_locs <= 1'b0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
